// File: rtl/sb_arbiter.sv
// sb_arbiter: shares one single-port system-bus memory between the core's
// instruction-fetch port and its data load/store port. Data accesses win
// over fetches. Store data and byte enables are lane-aligned on the way out,
// and sub-word load data is extended on the way back. hold_o stalls the
// pipeline while either port has an uncompleted request.
//
// Build option: define SB_ARB_TIMEOUT_EN to abort bus accesses that wait
// TIMEOUT cycles in ADDR or RESP. The abort completes the owner with zero
// data and sets the sticky err_o.
//
// state | meaning
// ------+---------------------------------------------
// IDLE  | no access in progress, arbitrating requests
// ADDR  | m_req held high, waiting for m_gnt
// RESP  | address accepted, waiting for m_rvalid
module sb_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          d_re,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [3:0]    d_byte_mask,
    input  logic          d_un_sign,
    output logic [DW-1:0] d_rdata,
    output logic          d_valid,
    output logic          hold_o,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic [3:0]    m_mask,
    input  logic          m_gnt,
    input  logic          m_rvalid,
    input  logic [DW-1:0] m_rdata,
    output logic          err_o
);

    typedef enum logic [1:0] {IDLE, ADDR, RESP} state_t;
    typedef enum logic {OWN_IF, OWN_D} owner_t;

    state_t        state, state_n;
    owner_t        owner, owner_n;
    logic          m_req_n, m_we_n;
    logic [AW-1:0] m_addr_n;
    logic [DW-1:0] m_wdata_n;
    logic [3:0]    m_mask_n;
    logic [DW-1:0] if_rdata_n, d_rdata_n;
    logic          if_valid_n, d_valid_n;
    logic [1:0]    ld_off, ld_off_n;
    logic          ld_byte, ld_byte_n;
    logic          ld_half, ld_half_n;
    logic          ld_uns, ld_uns_n;
    logic          abort;
    logic          tmo;
    logic          d_pend, i_pend;
    logic [DW-1:0] ld_shift, load_ext;

    // A port whose valid is high this cycle has just completed; do not re-issue it.
    assign d_pend = (d_re | d_we) & ~d_valid;
    assign i_pend = if_req & ~if_valid;

    // Stall while either port has a request that has not yet completed.
    assign hold_o = (if_req & ~if_valid) | ((d_re | d_we) & ~d_valid);

`ifdef SB_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // Wait counter restarts on every state change and counts cycles spent in ADDR/RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_n != state) begin
            wait_cnt <= '0;
        end else if (state != IDLE) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    assign tmo = (state != IDLE) && (wait_cnt == 4'(TIMEOUT - 1));

    // Sticky error flag, set by any aborted access and cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_o <= 1'b0;
        end else if (abort) begin
            err_o <= 1'b1;
        end
    end
`else
    assign tmo   = 1'b0;
    assign err_o = 1'b0;
`endif

    // Bring the addressed lane down to bit 0, then extend byte/half loads.
    always_comb begin
        ld_shift = m_rdata >> {ld_off, 3'b000};
        if (ld_byte) begin
            load_ext = {{(DW-8){~ld_uns & ld_shift[7]}}, ld_shift[7:0]};
        end else if (ld_half) begin
            load_ext = {{(DW-16){~ld_uns & ld_shift[15]}}, ld_shift[15:0]};
        end else begin
            load_ext = ld_shift;
        end
    end

    // State register and registered bus/port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            m_req    <= 1'b0;
            m_we     <= 1'b0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_mask   <= 4'b0000;
            if_rdata <= '0;
            d_rdata  <= '0;
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            ld_off   <= 2'b00;
            ld_byte  <= 1'b0;
            ld_half  <= 1'b0;
            ld_uns   <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            m_req    <= m_req_n;
            m_we     <= m_we_n;
            m_addr   <= m_addr_n;
            m_wdata  <= m_wdata_n;
            m_mask   <= m_mask_n;
            if_rdata <= if_rdata_n;
            d_rdata  <= d_rdata_n;
            if_valid <= if_valid_n;
            d_valid  <= d_valid_n;
            ld_off   <= ld_off_n;
            ld_byte  <= ld_byte_n;
            ld_half  <= ld_half_n;
            ld_uns   <= ld_uns_n;
        end
    end

    // Next-state and next-output logic: arbitration, handshake and completion.
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        m_req_n    = m_req;
        m_we_n     = m_we;
        m_addr_n   = m_addr;
        m_wdata_n  = m_wdata;
        m_mask_n   = m_mask;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        if_valid_n = 1'b0;
        d_valid_n  = 1'b0;
        ld_off_n   = ld_off;
        ld_byte_n  = ld_byte;
        ld_half_n  = ld_half;
        ld_uns_n   = ld_uns;
        abort      = 1'b0;

        case (state)
            IDLE: begin
                if (d_pend) begin
                    state_n   = ADDR;
                    owner_n   = OWN_D;
                    m_req_n   = 1'b1;
                    m_we_n    = d_we;
                    m_addr_n  = {d_addr[AW-1:2], 2'b00};
                    m_mask_n  = d_byte_mask << d_addr[1:0];
                    m_wdata_n = d_wdata << {d_addr[1:0], 3'b000};
                    ld_off_n  = d_addr[1:0];
                    ld_byte_n = ~d_byte_mask[1];
                    ld_half_n = d_byte_mask[1] & ~d_byte_mask[3];
                    ld_uns_n  = d_un_sign;
                end else if (i_pend) begin
                    state_n   = ADDR;
                    owner_n   = OWN_IF;
                    m_req_n   = 1'b1;
                    m_we_n    = 1'b0;
                    m_addr_n  = if_addr;
                    m_mask_n  = 4'b1111;
                    m_wdata_n = '0;
                end
            end
            ADDR: begin
                if (m_gnt) begin
                    state_n = RESP;
                    m_req_n = 1'b0;
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            RESP: begin
                if (m_rvalid) begin
                    state_n = IDLE;
                    if (owner == OWN_D) begin
                        d_rdata_n = load_ext;
                        d_valid_n = 1'b1;
                    end else begin
                        if_rdata_n = m_rdata;
                        if_valid_n = 1'b1;
                    end
                end else if (tmo) begin
                    abort = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                m_req_n = 1'b0;
            end
        endcase

        // An abandoned access completes its owner with zero data.
        if (abort) begin
            state_n = IDLE;
            m_req_n = 1'b0;
            if (owner == OWN_D) begin
                d_rdata_n = '0;
                d_valid_n = 1'b1;
            end else begin
                if_rdata_n = '0;
                if_valid_n = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sb_arbiter.sv
// Directed bench for sb_arbiter: a table of single transactions with
// hand-computed bus fields and load results, followed by hand-written
// sequences for arbitration order, same-port spacing, bus stall with reset,
// and the long-wait / timeout behaviour.
module tb_sb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_re = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_byte_mask = 4'b0000;
    logic        d_un_sign = 1'b0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        hold_o;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_mask;
    logic        m_gnt = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;
    int if_pulses = 0;
    int d_pulses = 0;

    sb_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_byte_mask(d_byte_mask), .d_un_sign(d_un_sign),
        .d_rdata(d_rdata), .d_valid(d_valid), .hold_o(hold_o),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_mask(m_mask),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Count valid pulses so each completion can be checked to occur once.
    always @(negedge clk) begin
        if (if_valid) if_pulses <= if_pulses + 1;
        if (d_valid)  d_pulses  <= d_pulses + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic        uns;
        logic [31:0] bus_rdata;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    // One transaction with grant one cycle after m_req and response the cycle after.
    task automatic run_vec(input vec_t v, input int idx);
        if (v.is_d) begin
            d_re = ~v.we; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
            d_byte_mask = v.mask; d_un_sign = v.uns;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        #1;
        check($sformatf("v%0d hold_at_req", idx), 32'(hold_o), 32'd1);
        @(negedge clk);
        check($sformatf("v%0d m_req", idx), 32'(m_req), 32'd1);
        check($sformatf("v%0d m_addr", idx), m_addr, v.exp_maddr);
        check($sformatf("v%0d m_mask", idx), 32'(m_mask), 32'(v.exp_mask));
        check($sformatf("v%0d m_we", idx), 32'(m_we), 32'(v.is_d & v.we));
        if (v.is_d && v.we)
            check($sformatf("v%0d m_wdata", idx), m_wdata, v.exp_wdata);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
        check($sformatf("v%0d m_req_drop", idx), 32'(m_req), 32'd0);
        check($sformatf("v%0d hold_wait", idx), 32'(hold_o), 32'd1);
        m_rvalid = 1'b1; m_rdata = v.bus_rdata;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0;
        check($sformatf("v%0d own_valid", idx), 32'(v.is_d ? d_valid : if_valid), 32'd1);
        check($sformatf("v%0d other_valid", idx), 32'(v.is_d ? if_valid : d_valid), 32'd0);
        check($sformatf("v%0d hold_done", idx), 32'(hold_o), 32'd0);
        if (!(v.is_d && v.we))
            check($sformatf("v%0d rdata", idx), v.is_d ? d_rdata : if_rdata, v.exp_rdata);
        if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d valid_pulse_end", idx), 32'(if_valid | d_valid), 32'd0);
    endtask

    initial begin
        int ip0, dp0;

        //          is_d we  addr          wdata         mask     uns  bus_rdata     m_addr        m_mask   m_wdata       rdata
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'b1111, 1'b0, 32'h00500093, 32'h100, 4'b1111, 32'h0,        32'h00500093};
        vecs[1] = '{1'b1, 1'b1, 32'h203, 32'hAB,       4'b0001, 1'b0, 32'h0,        32'h200, 4'b1000, 32'hAB000000, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h302, 32'h0,        4'b0011, 1'b0, 32'h80011234, 32'h300, 4'b1100, 32'h0,        32'hFFFF8001};
        vecs[3] = '{1'b1, 1'b0, 32'h302, 32'h0,        4'b0011, 1'b1, 32'h80011234, 32'h300, 4'b1100, 32'h0,        32'h00008001};
        vecs[4] = '{1'b1, 1'b0, 32'h401, 32'h0,        4'b0001, 1'b0, 32'h1234F678, 32'h400, 4'b0010, 32'h0,        32'hFFFFFFF6};
        vecs[5] = '{1'b1, 1'b0, 32'h402, 32'h0,        4'b0001, 1'b1, 32'h1234F678, 32'h400, 4'b0100, 32'h0,        32'h00000034};
        vecs[6] = '{1'b1, 1'b0, 32'h500, 32'h0,        4'b1111, 1'b0, 32'hDEADBEEF, 32'h500, 4'b1111, 32'h0,        32'hDEADBEEF};
        vecs[7] = '{1'b1, 1'b1, 32'h602, 32'h0000BEEF, 4'b0011, 1'b0, 32'h0,        32'h600, 4'b1100, 32'hBEEF0000, 32'h0};
        vecs[8] = '{1'b1, 1'b1, 32'h700, 32'h12345678, 4'b1111, 1'b0, 32'h0,        32'h700, 4'b1111, 32'h12345678, 32'h0};
        vecs[9] = '{1'b1, 1'b0, 32'h800, 32'h0,        4'b0011, 1'b0, 32'h00017FFF, 32'h800, 4'b0011, 32'h0,        32'h00007FFF};

        // Reset values
        #1;
        check("rst m_req", 32'(m_req), 32'd0);
        check("rst m_we", 32'(m_we), 32'd0);
        check("rst if_valid", 32'(if_valid), 32'd0);
        check("rst d_valid", 32'(d_valid), 32'd0);
        check("rst err_o", 32'(err_o), 32'd0);
        check("rst m_addr", m_addr, 32'd0);
        check("rst m_wdata", m_wdata, 32'd0);
        check("rst m_mask", 32'(m_mask), 32'd0);
        check("rst if_rdata", if_rdata, 32'd0);
        check("rst d_rdata", d_rdata, 32'd0);
        check("rst hold_o", 32'(hold_o), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // Simultaneous fetch and load: data first, fetch on the edge after d_valid
        ip0 = if_pulses; dp0 = d_pulses;
        if_req = 1'b1; if_addr = 32'h900;
        d_re = 1'b1; d_addr = 32'hA00; d_byte_mask = 4'b1111; d_un_sign = 1'b0;
        @(negedge clk);
        check("sim first_m_addr", m_addr, 32'hA00);
        check("sim first_m_req", 32'(m_req), 32'd1);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h11112222;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0;
        check("sim d_valid", 32'(d_valid), 32'd1);
        check("sim if_valid_early", 32'(if_valid), 32'd0);
        check("sim d_rdata", d_rdata, 32'h11112222);
        check("sim hold_fetch_pending", 32'(hold_o), 32'd1);
        d_re = 1'b0;
        @(negedge clk);
        check("sim fetch_m_req", 32'(m_req), 32'd1);
        check("sim fetch_m_addr", m_addr, 32'h900);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h33334444;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0;
        check("sim if_valid", 32'(if_valid), 32'd1);
        check("sim if_rdata", if_rdata, 32'h33334444);
        if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("sim if_pulse_count", 32'(if_pulses - ip0), 32'd1);
        check("sim d_pulse_count", 32'(d_pulses - dp0), 32'd1);

        // Same port held high: next request accepted one edge after the valid cycle
        d_re = 1'b1; d_addr = 32'hB00; d_byte_mask = 4'b1111;
        @(negedge clk);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h55;
        @(negedge clk);
        m_rvalid = 1'b0;
        check("same first_valid", 32'(d_valid), 32'd1);
        d_addr = 32'hC00;
        @(negedge clk);
        check("same gap_m_req", 32'(m_req), 32'd0);
        check("same gap_hold", 32'(hold_o), 32'd1);
        @(negedge clk);
        check("same second_m_req", 32'(m_req), 32'd1);
        check("same second_m_addr", m_addr, 32'hC00);
        m_rvalid = 1'b1; m_rdata = 32'h77;
        @(negedge clk);
        m_rvalid = 1'b0;
        check("same rvalid_in_addr_ignored", 32'(m_req), 32'd1);
        check("same no_valid_in_addr", 32'(d_valid), 32'd0);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h66;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0;
        check("same second_rdata", d_rdata, 32'h66);
        d_re = 1'b0;
        @(negedge clk);

        // Stalled grant, then reset mid-wait
        if_req = 1'b1; if_addr = 32'hD00;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("stall m_req_c%0d", k), 32'(m_req), 32'd1);
            check($sformatf("stall hold_c%0d", k), 32'(hold_o), 32'd1);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        check("stall rst_m_req", 32'(m_req), 32'd0);
        check("stall rst_m_addr", m_addr, 32'd0);
        check("stall rst_hold_req_high", 32'(hold_o), 32'd1);
        if_req = 1'b0;
        #1;
        check("stall rst_hold_req_low", 32'(hold_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        ip0 = if_pulses;
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("stall no_valid_after_rst", 32'(if_pulses - ip0), 32'd0);
        check("stall m_req_idle", 32'(m_req), 32'd0);

        // Response that never arrives
        d_re = 1'b1; d_addr = 32'hE00; d_byte_mask = 4'b1111; d_un_sign = 1'b0;
        @(negedge clk);
        m_gnt = 1'b1;
        @(negedge clk);
        m_gnt = 1'b0;
`ifdef SB_ARB_TIMEOUT_EN
        for (int k = 1; k < 16; k++) begin
            check($sformatf("tmo no_valid_c%0d", k), 32'(d_valid), 32'd0);
            @(negedge clk);
        end
        check("tmo d_valid", 32'(d_valid), 32'd1);
        check("tmo d_rdata", d_rdata, 32'd0);
        check("tmo err_o", 32'(err_o), 32'd1);
        d_re = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        check("tmo err_sticky", 32'(err_o), 32'd1);
        rst = 1'b0;
        #1;
        check("tmo err_cleared", 32'(err_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
`else
        dp0 = d_pulses;
        for (int k = 0; k < 20; k++) @(negedge clk);
        check("wait no_valid", 32'(d_pulses - dp0), 32'd0);
        check("wait err_o", 32'(err_o), 32'd0);
        check("wait hold_o", 32'(hold_o), 32'd1);
        check("wait m_req", 32'(m_req), 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
        @(negedge clk);
        m_rvalid = 1'b0; m_rdata = '0;
        check("wait late_valid", 32'(d_valid), 32'd1);
        check("wait late_rdata", d_rdata, 32'hCAFEF00D);
        d_re = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sb_arbiter.md
# sb_arbiter

Arbitrates the core's instruction-fetch port and data load/store port onto one shared single-port system-bus memory. Sits between the CoNM core and the system bus. Runs a request/grant/response handshake on the bus side and asserts a stall to the pipeline while any access is outstanding. Aligns store data and byte lanes, and sign- or zero-extends sub-word load data before returning it.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width, fixed at 32
- TIMEOUT, 15, bus wait cycles before abort; used only with SB_ARB_TIMEOUT_EN

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  AW  fetch address, word aligned
- if_rdata  out  DW  fetched instruction
- if_valid  out  1  one-cycle fetch completion
- d_re  in  1  load request
- d_we  in  1  store request; never high together with d_re
- d_addr  in  AW  data byte address
- d_wdata  in  DW  store data, right-justified
- d_byte_mask  in  4  size code: 0001 byte, 0011 half, 1111 word
- d_un_sign  in  1  1 = zero-extend load, 0 = sign-extend
- d_rdata  out  DW  extended load data
- d_valid  out  1  one-cycle data completion, loads and stores
- hold_o  out  1  pipeline stall
- m_req  out  1  bus request
- m_we  out  1  bus write
- m_addr  out  AW  bus address, {d_addr[AW-1:2],2'b00} for data accesses
- m_wdata  out  DW  lane-aligned store data
- m_mask  out  4  lane byte enables
- m_gnt  in  1  bus accepted the address phase
- m_rvalid  in  1  bus response; carries read data, or acknowledges a write
- m_rdata  in  DW  bus read word
- err_o  out  1  sticky timeout error

## Operation
- States:
  - IDLE: no access in progress.
  - ADDR: m_req is held high, waiting for m_gnt.
  - RESP: waiting for m_rvalid.
- An owner register records which port (IF or D) owns the current access.
- IDLE, at each edge:
  - A pending data access (d_re|d_we) wins; otherwise a pending if_req is taken. On a win: latch the bus fields and owner, go to ADDR.
  - A port whose valid is high in the current cycle is ineligible in that cycle. This prevents re-issuing a completed request.
- ADDR: when m_gnt is sampled high, go to RESP and drop m_req.
- RESP: when m_rvalid is sampled high, register the result to the owner's rdata, pulse the owner's valid, go to IDLE.
- Store alignment:
  - m_mask = d_byte_mask << d_addr[1:0].
  - m_wdata = d_wdata << 8*d_addr[1:0].
- Load extension:
  - Shift m_rdata right by 8*d_addr[1:0].
  - Byte: extend bit 7. Half: extend bit 15. Word: pass through.
  - d_un_sign selects zero- or sign-extension.
- Fetch accesses use m_we=0 and m_mask=1111.
- hold_o = (if_req & ~if_valid) | ((d_re|d_we) & ~d_valid), combinational.
- Misaligned accesses are not checked; the core guarantees alignment.

## Timing
- Reset values: state IDLE; m_req, m_we, if_valid, d_valid, err_o = 0; m_addr, m_wdata, if_rdata, d_rdata = 0; m_mask = 0000.
- All outputs except hold_o are registered.
- Minimum latency is 3 edges from request sampled in IDLE to valid high:
  - E0: request sampled, m_req rises.
  - E1: m_gnt sampled, m_req falls.
  - E2: m_rvalid sampled.
  - Valid is high in the cycle after E2.
- Back-to-back: a different port's request is accepted at the edge ending the valid cycle. The same port's next request is accepted one edge later.
- Requests arriving while not in IDLE wait; requesters hold address and data stable until their valid.
- m_rvalid in IDLE or ADDR is ignored. m_gnt in RESP or IDLE is ignored.
- Reset asserted mid-access returns immediately to reset values; the in-flight bus transaction is abandoned.

## Configuration
- SB_ARB_TIMEOUT_EN defined:
  - A 4-bit wait counter clears on entering ADDR or RESP and increments each cycle spent there.
  - On reaching TIMEOUT: drop m_req, return to IDLE, pulse the owner's valid with rdata = 0, set err_o.
  - err_o stays high until reset.
- Not defined: ADDR and RESP wait indefinitely; err_o is constant 0; no counter logic exists.

## Test plan
- Fetch only: if_req=1, if_addr=0x100; m_gnt one cycle after m_req; m_rvalid next cycle with m_rdata=0x00500093 -> if_rdata=0x00500093, if_valid pulses once 3 cycles after request, hold_o high until then.
- Simultaneous: if_req and d_re raised on the same edge -> data access granted first; fetch issued on the edge after d_valid; each valid pulses exactly once.
- Byte store: d_we=1, d_addr=0x203, d_wdata=0xAB, mask 0001 -> m_addr=0x200, m_mask=1000, m_wdata=0xAB000000, m_we=1.
- Signed half load: d_addr=0x302, mask 0011, d_un_sign=0, m_rdata=0x8001_1234 -> d_rdata=0xFFFF8001; with d_un_sign=1 -> 0x00008001.
- Stalled bus: m_gnt held low 5 cycles -> m_req stays high, state ADDR, hold_o high. Assert rst mid-wait -> m_req=0, hold logic recomputes, no valid pulse.
- With SB_ARB_TIMEOUT_EN, m_rvalid never arrives -> after 15 RESP cycles, owner valid pulses with rdata=0 and err_o=1 until rst.
